// File: rtl/axi_arb_pkg.sv
// Shared types and AXI constants for the interconnect read/write arbiters.
package axi_arb_pkg;

  // Arbiter FSM: wait for a request, forward the address, stream the burst.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Index of the master that currently owns the slave port.
  typedef logic owner_t;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI burst types.
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Remaining-beat counter step; holds at zero so an over-long burst
  // keeps reporting a mismatch instead of wrapping to 255.
  function automatic logic [7:0] beat_cnt_dec(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
  endfunction

endpackage

// File: rtl/axi_rr_pick2.sv
// Two-requester round-robin picker: a lone requester wins outright, a tie
// goes to whichever master did not own the port last.
module axi_rr_pick2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic       valid,
  output owner_t     winner
);

  // Pure combinational pick; no state of its own.
  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last_owner : req[1];
  end

endmodule

// File: rtl/axi_arbiter_rd.sv
// Read-channel arbiter: two AXI4 masters share one AXI4 slave read port.
// One burst outstanding at a time; the grant is held until the RLAST beat.
module axi_arbiter_rd
  import axi_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // master 0
  input  logic [ID_WIDTH-1:0]   m0_ARID,
  input  logic [ADDR_WIDTH-1:0] m0_ARADDR,
  input  logic [7:0]            m0_ARLEN,
  input  logic [2:0]            m0_ARSIZE,
  input  logic [1:0]            m0_ARBURST,
  input  logic                  m0_ARVALID,
  output logic                  m0_ARREADY,
  output logic [ID_WIDTH-1:0]   m0_RID,
  output logic [DATA_WIDTH-1:0] m0_RDATA,
  output logic [1:0]            m0_RRESP,
  output logic                  m0_RLAST,
  output logic                  m0_RVALID,
  input  logic                  m0_RREADY,
  // master 1
  input  logic [ID_WIDTH-1:0]   m1_ARID,
  input  logic [ADDR_WIDTH-1:0] m1_ARADDR,
  input  logic [7:0]            m1_ARLEN,
  input  logic [2:0]            m1_ARSIZE,
  input  logic [1:0]            m1_ARBURST,
  input  logic                  m1_ARVALID,
  output logic                  m1_ARREADY,
  output logic [ID_WIDTH-1:0]   m1_RID,
  output logic [DATA_WIDTH-1:0] m1_RDATA,
  output logic [1:0]            m1_RRESP,
  output logic                  m1_RLAST,
  output logic                  m1_RVALID,
  input  logic                  m1_RREADY,
  // slave
  output logic [ID_WIDTH-1:0]   s_ARID,
  output logic [ADDR_WIDTH-1:0] s_ARADDR,
  output logic [7:0]            s_ARLEN,
  output logic [2:0]            s_ARSIZE,
  output logic [1:0]            s_ARBURST,
  output logic                  s_ARVALID,
  input  logic                  s_ARREADY,
  input  logic [ID_WIDTH-1:0]   s_RID,
  input  logic [DATA_WIDTH-1:0] s_RDATA,
  input  logic [1:0]            s_RRESP,
  input  logic                  s_RLAST,
  input  logic                  s_RVALID,
  output logic                  s_RREADY,
  // status
  output logic                  m0_rgrnt,
  output logic                  m1_rgrnt,
  output logic                  rlast_err
);

  arb_state_e state_q, state_d;
  owner_t     owner_q, owner_d;
  owner_t     last_owner_q, last_owner_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       rlast_err_q, rlast_err_d;

  logic   pick_valid;
  owner_t pick_winner;
  logic   in_addr, in_data;
  logic   r_hs;

  axi_rr_pick2 u_pick (
    .req        ({m1_ARVALID, m0_ARVALID}),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  // s_RREADY is already gated to DATA, so this only fires on owned beats.
  assign r_hs    = s_RVALID & s_RREADY;

  // Next-state logic: grant in IDLE, count beats in DATA, flag RLAST mismatch.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    rlast_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (s_ARVALID && s_ARREADY) begin
          beat_cnt_d = s_ARLEN;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_cnt_d  = beat_cnt_dec(beat_cnt_q);
          rlast_err_d = s_RLAST ^ (beat_cnt_q == 8'd0);
          if (s_RLAST) begin
            last_owner_d = owner_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; m0 wins the first tie.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // value of the others, independent of statement order.
    if (ARESET) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= 8'd0;
      rlast_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rlast_err_q  <= rlast_err_d;
    end
  end

  // Owner mux for the address path; payload is unregistered and only
  // qualified by s_ARVALID.
  always_comb begin
    s_ARID     = owner_q ? m1_ARID    : m0_ARID;
    s_ARADDR   = owner_q ? m1_ARADDR  : m0_ARADDR;
    s_ARLEN    = owner_q ? m1_ARLEN   : m0_ARLEN;
    s_ARSIZE   = owner_q ? m1_ARSIZE  : m0_ARSIZE;
    s_ARBURST  = owner_q ? m1_ARBURST : m0_ARBURST;
    s_ARVALID  = in_addr & (owner_q ? m1_ARVALID : m0_ARVALID);
    m0_ARREADY = in_addr & ~owner_q & s_ARREADY;
    m1_ARREADY = in_addr &  owner_q & s_ARREADY;
  end

  // Read-data routing: only the owner sees RVALID; payload is broadcast
  // during DATA and held at zero otherwise so unsolicited beats go nowhere.
  always_comb begin
    s_RREADY  = in_data & (owner_q ? m1_RREADY : m0_RREADY);
    m0_RVALID = in_data & ~owner_q & s_RVALID;
    m1_RVALID = in_data &  owner_q & s_RVALID;
    m0_RID    = in_data ? s_RID   : '0;
    m0_RDATA  = in_data ? s_RDATA : '0;
    m0_RRESP  = in_data ? s_RRESP : '0;
    m0_RLAST  = in_data & s_RLAST;
    m1_RID    = m0_RID;
    m1_RDATA  = m0_RDATA;
    m1_RRESP  = m0_RRESP;
    m1_RLAST  = m0_RLAST;
  end

  // Grant and error status outputs.
  always_comb begin
    m0_rgrnt  = (state_q != IDLE) & ~owner_q;
    m1_rgrnt  = (state_q != IDLE) &  owner_q;
    rlast_err = rlast_err_q;
  end

endmodule

// File: tb/tb_axi_arbiter_rd.sv
// Directed bench for axi_arbiter_rd: a table of per-cycle vectors with
// hand-computed handshake/grant outputs, then a hand-written payload burst.
module tb_axi_arbiter_rd;
  import axi_arb_pkg::*;

  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [IW-1:0] M0_ID   = 4'h3;
  localparam logic [AW-1:0] M0_ADDR = 32'h0000_1000;
  localparam logic [IW-1:0] M1_ID   = 4'hA;
  localparam logic [AW-1:0] M1_ADDR = 32'h8000_2000;

  // Expected output bits:
  // {s_ARVALID, m0_ARREADY, m1_ARREADY, s_RREADY, m0_RVALID, m1_RVALID,
  //  m1_rgrnt, m0_rgrnt, rlast_err}
  localparam logic [8:0] E_IDLE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] E_ERR  = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] E_A0W  = 9'b1_0_0_0_0_0_0_1_0;
  localparam logic [8:0] E_A0H  = 9'b1_1_0_0_0_0_0_1_0;
  localparam logic [8:0] E_A0R  = 9'b0_1_0_0_0_0_0_1_0;
  localparam logic [8:0] E_A1H  = 9'b1_0_1_0_0_0_1_0_0;
  localparam logic [8:0] E_D0   = 9'b0_0_0_1_1_0_0_1_0;
  localparam logic [8:0] E_D1   = 9'b0_0_0_1_0_1_1_0_0;
  localparam logic [8:0] E_D1S  = 9'b0_0_0_0_0_1_1_0_0;
  localparam logic [8:0] E_D1E  = 9'b0_0_0_1_0_1_1_0_1;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic [IW-1:0] m0_ARID, m1_ARID, s_ARID, m0_RID, m1_RID, s_RID;
  logic [AW-1:0] m0_ARADDR, m1_ARADDR, s_ARADDR;
  logic [7:0]    m0_ARLEN, m1_ARLEN, s_ARLEN;
  logic [2:0]    m0_ARSIZE, m1_ARSIZE, s_ARSIZE;
  logic [1:0]    m0_ARBURST, m1_ARBURST, s_ARBURST;
  logic          m0_ARVALID, m1_ARVALID, s_ARVALID;
  logic          m0_ARREADY, m1_ARREADY, s_ARREADY;
  logic [DW-1:0] m0_RDATA, m1_RDATA, s_RDATA;
  logic [1:0]    m0_RRESP, m1_RRESP, s_RRESP;
  logic          m0_RLAST, m1_RLAST, s_RLAST;
  logic          m0_RVALID, m1_RVALID, s_RVALID;
  logic          m0_RREADY, m1_RREADY, s_RREADY;
  logic          m0_rgrnt, m1_rgrnt, rlast_err;

  axi_arbiter_rd #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_ARID(m0_ARID), .m0_ARADDR(m0_ARADDR), .m0_ARLEN(m0_ARLEN),
    .m0_ARSIZE(m0_ARSIZE), .m0_ARBURST(m0_ARBURST), .m0_ARVALID(m0_ARVALID),
    .m0_ARREADY(m0_ARREADY), .m0_RID(m0_RID), .m0_RDATA(m0_RDATA),
    .m0_RRESP(m0_RRESP), .m0_RLAST(m0_RLAST), .m0_RVALID(m0_RVALID),
    .m0_RREADY(m0_RREADY),
    .m1_ARID(m1_ARID), .m1_ARADDR(m1_ARADDR), .m1_ARLEN(m1_ARLEN),
    .m1_ARSIZE(m1_ARSIZE), .m1_ARBURST(m1_ARBURST), .m1_ARVALID(m1_ARVALID),
    .m1_ARREADY(m1_ARREADY), .m1_RID(m1_RID), .m1_RDATA(m1_RDATA),
    .m1_RRESP(m1_RRESP), .m1_RLAST(m1_RLAST), .m1_RVALID(m1_RVALID),
    .m1_RREADY(m1_RREADY),
    .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN),
    .s_ARSIZE(s_ARSIZE), .s_ARBURST(s_ARBURST), .s_ARVALID(s_ARVALID),
    .s_ARREADY(s_ARREADY), .s_RID(s_RID), .s_RDATA(s_RDATA),
    .s_RRESP(s_RRESP), .s_RLAST(s_RLAST), .s_RVALID(s_RVALID),
    .s_RREADY(s_RREADY),
    .m0_rgrnt(m0_rgrnt), .m1_rgrnt(m1_rgrnt), .rlast_err(rlast_err)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       m0_v;
    logic       m1_v;
    logic [7:0] m0_len;
    logic [7:0] m1_len;
    logic       ar_rdy;
    logic       r_v;
    logic       r_last;
    logic       m0_rr;
    logic       m1_rr;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic rst, input logic m0_v, input logic m1_v,
                     input logic [7:0] m0_len, input logic [7:0] m1_len, input logic ar_rdy,
                     input logic r_v, input logic r_last, input logic m0_rr, input logic m1_rr,
                     input logic [8:0] exp);
    vec_t v;
    v.name = name;  v.rst = rst;  v.m0_v = m0_v;  v.m1_v = m1_v;
    v.m0_len = m0_len;  v.m1_len = m1_len;  v.ar_rdy = ar_rdy;
    v.r_v = r_v;  v.r_last = r_last;  v.m0_rr = m0_rr;  v.m1_rr = m1_rr;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [8:0] outs();
    return {s_ARVALID, m0_ARREADY, m1_ARREADY, s_RREADY, m0_RVALID, m1_RVALID,
            m1_rgrnt, m0_rgrnt, rlast_err};
  endfunction

  task automatic apply(input vec_t v, input int idx);
    ARESET     = v.rst;
    m0_ARVALID = v.m0_v;
    m1_ARVALID = v.m1_v;
    m0_ARLEN   = v.m0_len;
    m1_ARLEN   = v.m1_len;
    s_ARREADY  = v.ar_rdy;
    s_RVALID   = v.r_v;
    s_RLAST    = v.r_last;
    m0_RREADY  = v.m0_rr;
    m1_RREADY  = v.m1_rr;
    s_RDATA    = 32'hD000_0000 + 32'(idx);
  endtask

  initial begin
    // Tie after reset -> m0, then m1, then m0 again.
    add("tie0_idle",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    add("tie0_addr",    0, 1, 1, 0, 0, 1, 0, 0, 0, 0, E_A0H);
    add("tie0_beat",    0, 0, 1, 0, 0, 0, 1, 1, 1, 1, E_D0);
    add("tie1_idle",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    add("tie1_addr",    0, 1, 1, 0, 0, 1, 0, 0, 0, 0, E_A1H);
    add("tie1_beat",    0, 1, 0, 0, 0, 0, 1, 1, 1, 1, E_D1);
    add("tie2_idle",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    add("tie2_wait",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_A0W);
    add("tie2_addr",    0, 1, 1, 3, 0, 1, 0, 0, 0, 0, E_A0H);
    // m0 ARLEN=3: four beats, last one carries RLAST.
    add("b4_beat1",     0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_D0);
    add("b4_beat2",     0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_D0);
    add("b4_beat3",     0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_D0);
    add("b4_beat4",     0, 0, 0, 0, 0, 0, 1, 1, 1, 0, E_D0);
    add("b4_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    // m1 ARLEN=2 with RVALID held and m1 RREADY toggling.
    add("rr_idle",      0, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    add("rr_addr",      0, 0, 1, 0, 2, 1, 0, 0, 0, 0, E_A1H);
    add("rr_stall1",    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_D1S);
    add("rr_beat1",     0, 0, 0, 0, 0, 0, 1, 0, 1, 1, E_D1);
    add("rr_stall2",    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_D1S);
    add("rr_beat2",     0, 0, 0, 0, 0, 0, 1, 0, 1, 1, E_D1);
    add("rr_stall3",    0, 0, 0, 0, 0, 0, 1, 1, 1, 0, E_D1S);
    add("rr_beat3",     0, 0, 0, 0, 0, 0, 1, 1, 1, 1, E_D1);
    add("rr_idle2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    // m0 ARLEN=1 but RLAST on the first beat: early end, one error pulse.
    add("short_idle",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    add("short_addr",   0, 1, 0, 1, 0, 1, 0, 0, 0, 0, E_A0H);
    add("short_last",   0, 0, 0, 0, 0, 0, 1, 1, 1, 0, E_D0);
    add("short_err",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ERR);
    add("short_clr",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    // m1 ARLEN=0 but no RLAST on beat 1: error, burst continues to RLAST.
    add("long_idle",    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    add("long_addr",    0, 0, 1, 0, 0, 1, 0, 0, 0, 0, E_A1H);
    add("long_nolast",  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, E_D1);
    add("long_last",    0, 0, 0, 0, 0, 0, 1, 1, 0, 1, E_D1E);
    add("unsol_idle_r", 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, E_IDLE);
    // Unsolicited beat in ADDR, then owner drops ARVALID and keeps the grant.
    add("unsol_idle",   0, 1, 0, 0, 0, 0, 1, 0, 0, 0, E_IDLE);
    add("unsol_addr",   0, 1, 0, 0, 0, 0, 1, 1, 1, 1, E_A0W);
    add("drop_arvalid", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, E_A0R);
    add("re_arvalid",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_A0W);
    // Reset after 2 of 8 beats; the following tie goes to m0.
    add("rst_addr",     0, 1, 0, 7, 0, 1, 0, 0, 0, 0, E_A0H);
    add("rst_beat1",    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_D0);
    add("rst_beat2",    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_D0);
    add("rst_assert",   1, 1, 1, 0, 0, 0, 1, 0, 1, 0, E_D0);
    add("rst_idle",     0, 1, 1, 0, 0, 0, 1, 0, 1, 0, E_IDLE);
    add("rst_tie",      0, 1, 1, 0, 0, 0, 1, 0, 1, 0, E_A0W);
    add("rst_addr2",    0, 1, 0, 0, 0, 1, 0, 0, 0, 0, E_A0H);
    add("rst_done",     0, 0, 0, 0, 0, 0, 1, 1, 1, 0, E_D0);
    add("final_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);

    // Reset with quiet masters but a busy slave: every output must be 0.
    ARESET = 1'b1;
    m0_ARID = '0; m0_ARADDR = '0; m0_ARLEN = '0; m0_ARSIZE = '0; m0_ARBURST = '0;
    m1_ARID = '0; m1_ARADDR = '0; m1_ARLEN = '0; m1_ARSIZE = '0; m1_ARBURST = '0;
    m0_ARVALID = 1'b0; m1_ARVALID = 1'b0; m0_RREADY = 1'b1; m1_RREADY = 1'b1;
    s_ARREADY = 1'b1; s_RID = 4'h5; s_RDATA = 32'hCAFE_F00D; s_RRESP = RESP_EXOKAY;
    s_RLAST = 1'b1; s_RVALID = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    #1;
    check("reset_ctrl", 64'(outs()), 64'(E_IDLE));
    check("reset_m0_r", {m0_RID, m0_RDATA, m0_RRESP, m0_RLAST}, 64'd0);
    check("reset_m1_r", {m1_RID, m1_RDATA, m1_RRESP, m1_RLAST}, 64'd0);
    check("reset_s_ar", {s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST}, 64'd0);
    @(posedge ACLK);
    #1;

    m0_ARID = M0_ID; m0_ARADDR = M0_ADDR; m0_ARSIZE = 3'd2; m0_ARBURST = BURST_INCR;
    m1_ARID = M1_ID; m1_ARADDR = M1_ADDR; m1_ARSIZE = 3'd1; m1_ARBURST = BURST_WRAP;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
      #1;
      check(vecs[i].name, 64'(outs()), 64'(vecs[i].exp));
      if (vecs[i].exp[1])
        check({vecs[i].name, "_ar_m0"}, {s_ARADDR, s_ARLEN}, {M0_ADDR, vecs[i].m0_len});
      if (vecs[i].exp[2])
        check({vecs[i].name, "_ar_m1"}, {s_ARADDR, s_ARLEN}, {M1_ADDR, vecs[i].m1_len});
      if (vecs[i].exp[4])
        check({vecs[i].name, "_r_m0"}, {m0_RID, m0_RDATA, m0_RRESP, m0_RLAST},
              {s_RID, s_RDATA, s_RRESP, vecs[i].r_last});
      if (vecs[i].exp[3])
        check({vecs[i].name, "_r_m1"}, {m1_RID, m1_RDATA, m1_RRESP, m1_RLAST},
              {s_RID, s_RDATA, s_RRESP, vecs[i].r_last});
      @(posedge ACLK);
      #1;
    end

    // Hand-written m1 burst: full AR payload mux and R payload routing.
    begin
      int hs_count;
      hs_count = 0;
      ARESET = 1'b0; m0_ARVALID = 1'b0; m1_ARVALID = 1'b1; m1_ARLEN = 8'd5;
      s_ARREADY = 1'b0; s_RVALID = 1'b0; s_RLAST = 1'b0; m0_RREADY = 1'b1; m1_RREADY = 1'b1;
      #1;
      check("pay_idle", 64'(outs()), 64'(E_IDLE));
      @(posedge ACLK);
      #1;
      check("pay_ar", {s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARVALID},
            {M1_ID, M1_ADDR, 8'd5, 3'd1, BURST_WRAP, 1'b1});
      s_ARREADY = 1'b1;
      @(posedge ACLK);
      #1;
      m1_ARVALID = 1'b0; s_ARREADY = 1'b0;
      for (int b = 0; b < 6; b++) begin
        s_RVALID = 1'b1;
        s_RID    = M1_ID;
        s_RDATA  = 32'hA5A5_0000 + 32'(b);
        s_RRESP  = (b == 5) ? RESP_SLVERR : RESP_OKAY;
        s_RLAST  = (b == 5);
        #1;
        if (s_RREADY && s_RVALID) hs_count++;
        check($sformatf("pay_beat%0d", b),
              {m1_RVALID, m0_RVALID, m1_RID, m1_RDATA, m1_RRESP, m1_RLAST},
              {1'b1, 1'b0, M1_ID, 32'hA5A5_0000 + 32'(b),
               (b == 5) ? RESP_SLVERR : RESP_OKAY, b == 5});
        @(posedge ACLK);
        #1;
      end
      s_RVALID = 1'b0; s_RLAST = 1'b0;
      #1;
      check("pay_handshakes", 64'(hs_count), 64'd6);
      check("pay_end_idle", 64'(outs()), 64'(E_IDLE));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
